test_monitor: RTL and testbench

TEST_MONITOR -- requirements
Module: test_monitor

---
 rtl/test_monitor.sv | 233 +++++++++++++++++++++++
 tb/tb_test_monitor.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/test_monitor.sv
// -----------------------------------------------------------------------------
// test_monitor
//
// Watches the CPU write bus for self-test status writes to a single port
// (STATUS_ADDR) and reports the test verdict.
//
//   status 8'h00        -> PASS (terminal)
//   status 8'h01..8'h7F -> checkpoint; must arrive in order 1, 2, 3 ...,
//                          otherwise FAIL with seq_err
//   status 8'h80..8'hFF -> FAIL with fail_code = status value
//
// Optional feature, enabled by defining macro TEST_MONITOR_WATCHDOG_EN:
//   a 16-bit watchdog counts RUN cycles since the last status write and
//   forces FAIL with timeout=1 when it would reach TIMEOUT. Without the
//   macro there is no watchdog and timeout is tied to 0.
//
// Parameters
//   STATUS_ADDR  CPU bus address of the status port
//   TIMEOUT      watchdog limit in ph1 cycles without a status write
//
// Ports
//   ph1          in   clock, all state changes on the rising edge
//   reset        in   asynchronous active-high reset
//   address      in   [15:0] CPU bus address
//   data_out     in   [7:0]  CPU write data
//   memwrite     in   CPU write strobe
//   done         out  test terminated
//   pass         out  test terminated successfully
//   fail_code    out  [7:0] failing status value, else 8'h00
//   seq_err      out  checkpoint arrived out of order
//   timeout      out  watchdog expired
//   checkpoints  out  [7:0] count of in-order checkpoints
//   cycles       out  [15:0] ph1 cycles spent in RUN, saturating
// -----------------------------------------------------------------------------
module test_monitor #(
  parameter logic [15:0] STATUS_ADDR = 16'h0200,
  parameter logic [15:0] TIMEOUT     = 16'd1000
) (
  input  logic        ph1,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic [7:0]  data_out,
  input  logic        memwrite,
  output logic        done,
  output logic        pass,
  output logic [7:0]  fail_code,
  output logic        seq_err,
  output logic        timeout,
  output logic [7:0]  checkpoints,
  output logic [15:0] cycles
);

  localparam logic [1:0] S_RUN  = 2'd0;
  localparam logic [1:0] S_PASS = 2'd1;
  localparam logic [1:0] S_FAIL = 2'd2;

  // Registered state
  logic [1:0]  r_state;
  logic        r_done;
  logic        r_pass;
  logic [7:0]  r_fail_code;
  logic        r_seq_err;
  logic [7:0]  r_checkpoints;
  logic [7:0]  r_expected;
  logic [15:0] r_cycles;

  // Next-state values
  logic [1:0]  w_state_nxt;
  logic        w_done_nxt;
  logic        w_pass_nxt;
  logic [7:0]  w_fail_code_nxt;
  logic        w_seq_err_nxt;
  logic [7:0]  w_checkpoints_nxt;
  logic [7:0]  w_expected_nxt;
  logic [15:0] w_cycles_nxt;

  // Decode helpers
  logic        w_in_run;
  logic        w_status_wr;
  logic        w_is_pass_code;
  logic        w_is_fail_code;
  logic        w_ckpt_in_order;
  logic [15:0] w_cycles_inc;
  logic        w_wd_expire;

  assign w_in_run        = (r_state == S_RUN);
  // Full 16-bit compare; no partial decode of neighbouring addresses.
  assign w_status_wr     = memwrite && (address == STATUS_ADDR);
  assign w_is_pass_code  = (data_out == 8'h00);
  assign w_is_fail_code  = data_out[7];
  // Only meaningful when the value is a checkpoint (8'h01..8'h7F).
  // Once expected has moved to 8'h80 no checkpoint can ever match it.
  assign w_ckpt_in_order = (data_out == r_expected);
  assign w_cycles_inc    = (r_cycles == 16'hFFFF) ? r_cycles : (r_cycles + 16'd1);

`ifdef TEST_MONITOR_WATCHDOG_EN
  logic [15:0] r_wd;
  logic [15:0] w_wd_nxt;
  logic [15:0] w_wd_inc;
  logic        r_timeout;
  logic        w_timeout_nxt;

  assign w_wd_inc    = r_wd + 16'd1;
  // Expire on the edge where the counter would reach the limit.
  assign w_wd_expire = w_in_run && (w_wd_inc >= TIMEOUT);

  // Watchdog next value: clears on any status write, counts RUN cycles.
  always_comb begin
    w_wd_nxt = r_wd;
    if (w_in_run) begin
      if (w_status_wr) begin
        w_wd_nxt = 16'h0000;
      end else begin
        w_wd_nxt = w_wd_inc;
      end
    end else begin
      w_wd_nxt = r_wd;
    end
  end

  // Watchdog counter and timeout flag registers.
  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) begin
      r_wd      <= 16'h0000;
      r_timeout <= 1'b0;
    end else begin
      r_wd      <= w_wd_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  assign timeout = r_timeout;
`else
  assign w_wd_expire = 1'b0;
  assign timeout     = 1'b0;
`endif

  // Verdict FSM next-state and output decode.
  always_comb begin
    w_state_nxt       = r_state;
    w_done_nxt        = r_done;
    w_pass_nxt        = r_pass;
    w_fail_code_nxt   = r_fail_code;
    w_seq_err_nxt     = r_seq_err;
    w_checkpoints_nxt = r_checkpoints;
    w_expected_nxt    = r_expected;
    w_cycles_nxt      = r_cycles;
`ifdef TEST_MONITOR_WATCHDOG_EN
    w_timeout_nxt     = r_timeout;
`endif

    case (r_state)
      S_RUN: begin
        // The terminating edge is counted too.
        w_cycles_nxt = w_cycles_inc;
        if (w_status_wr) begin
          // A status write wins over a simultaneous watchdog expiry.
          if (w_is_pass_code) begin
            w_state_nxt = S_PASS;
            w_done_nxt  = 1'b1;
            w_pass_nxt  = 1'b1;
          end else if (w_is_fail_code) begin
            w_state_nxt     = S_FAIL;
            w_done_nxt      = 1'b1;
            w_fail_code_nxt = data_out;
          end else if (w_ckpt_in_order) begin
            w_checkpoints_nxt = r_checkpoints + 8'd1;
            w_expected_nxt    = r_expected + 8'd1;
          end else begin
            w_state_nxt     = S_FAIL;
            w_done_nxt      = 1'b1;
            w_seq_err_nxt   = 1'b1;
            w_fail_code_nxt = data_out;
          end
        end else if (w_wd_expire) begin
          w_state_nxt     = S_FAIL;
          w_done_nxt      = 1'b1;
          w_fail_code_nxt = 8'h00;
`ifdef TEST_MONITOR_WATCHDOG_EN
          w_timeout_nxt   = 1'b1;
`endif
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_PASS: begin
        // Terminal: everything holds until reset.
        w_state_nxt = S_PASS;
      end
      S_FAIL: begin
        w_state_nxt = S_FAIL;
      end
      default: begin
        // Unreachable encoding: fail safe with a visible verdict.
        w_state_nxt     = S_FAIL;
        w_done_nxt      = 1'b1;
        w_pass_nxt      = 1'b0;
        w_fail_code_nxt = 8'h00;
      end
    endcase
  end

  // Verdict FSM and counter registers.
  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) begin
      r_state       <= S_RUN;
      r_done        <= 1'b0;
      r_pass        <= 1'b0;
      r_fail_code   <= 8'h00;
      r_seq_err     <= 1'b0;
      r_checkpoints <= 8'h00;
      r_expected    <= 8'h01;
      r_cycles      <= 16'h0000;
    end else begin
      r_state       <= w_state_nxt;
      r_done        <= w_done_nxt;
      r_pass        <= w_pass_nxt;
      r_fail_code   <= w_fail_code_nxt;
      r_seq_err     <= w_seq_err_nxt;
      r_checkpoints <= w_checkpoints_nxt;
      r_expected    <= w_expected_nxt;
      r_cycles      <= w_cycles_nxt;
    end
  end

  assign done        = r_done;
  assign pass        = r_pass;
  assign fail_code   = r_fail_code;
  assign seq_err     = r_seq_err;
  assign checkpoints = r_checkpoints;
  assign cycles      = r_cycles;

endmodule

// File: tb/tb_test_monitor.sv
// Directed testbench for test_monitor. Inputs change on the falling edge of
// ph1 and outputs are sampled on the falling edge after the rising edge that
// consumed them.
module tb_test_monitor;

  logic        ph1;
  logic        reset;
  logic [15:0] address;
  logic [7:0]  data_out;
  logic        memwrite;
  logic        done;
  logic        pass;
  logic [7:0]  fail_code;
  logic        seq_err;
  logic        timeout;
  logic [7:0]  checkpoints;
  logic [15:0] cycles;

  int n_checks;
  int n_fails;

  test_monitor #(
    .STATUS_ADDR (16'h0200),
    .TIMEOUT     (16'd10)
  ) dut (
    .ph1         (ph1),
    .reset       (reset),
    .address     (address),
    .data_out    (data_out),
    .memwrite    (memwrite),
    .done        (done),
    .pass        (pass),
    .fail_code   (fail_code),
    .seq_err     (seq_err),
    .timeout     (timeout),
    .checkpoints (checkpoints),
    .cycles      (cycles)
  );

  initial ph1 = 1'b0;
  always #5 ph1 = ~ph1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic e_done, input logic e_pass,
                           input logic [7:0] e_fc, input logic e_seq, input logic e_to,
                           input logic [7:0] e_ck, input logic [15:0] e_cyc);
    check({tag, ".done"},        {31'd0, done},        {31'd0, e_done});
    check({tag, ".pass"},        {31'd0, pass},        {31'd0, e_pass});
    check({tag, ".fail_code"},   {24'd0, fail_code},   {24'd0, e_fc});
    check({tag, ".seq_err"},     {31'd0, seq_err},     {31'd0, e_seq});
    check({tag, ".timeout"},     {31'd0, timeout},     {31'd0, e_to});
    check({tag, ".checkpoints"}, {24'd0, checkpoints}, {24'd0, e_ck});
    check({tag, ".cycles"},      {16'd0, cycles},      {16'd0, e_cyc});
  endtask

  // Called at a falling edge; leaves reset released at a falling edge.
  // A status write of 8'h00 is held on the bus during reset and must be ignored.
  task automatic do_reset();
    @(negedge ph1);
    reset    = 1'b1;
    address  = 16'h0200;
    data_out = 8'h00;
    memwrite = 1'b1;
    @(negedge ph1);
    @(negedge ph1);
    memwrite = 1'b0;
    reset    = 1'b0;
  endtask

  // Called at a falling edge; one rising edge consumes the write.
  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    address  = a;
    data_out = d;
    memwrite = 1'b1;
    @(negedge ph1);
    memwrite = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge ph1);
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    reset    = 1'b1;
    address  = 16'h0000;
    data_out = 8'h00;
    memwrite = 1'b0;
    #1;
    check_out("reset", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 16'd0);
    @(negedge ph1);
    reset = 1'b0;

    // Three in-order checkpoints then pass.
    wr(16'h0200, 8'h01);
    wr(16'h0200, 8'h02);
    wr(16'h0200, 8'h03);
    check_out("ckpt3", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h03, 16'd3);
    wr(16'h0200, 8'h00);
    check_out("pass", 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 8'h03, 16'd4);
    idle(3);
    wr(16'h0200, 8'h85);
    check_out("pass_hold", 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 8'h03, 16'd4);

    // Out-of-order checkpoint.
    do_reset();
    check_out("rst_seq", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 16'd0);
    wr(16'h0200, 8'h01);
    wr(16'h0200, 8'h03);
    check_out("seq_err", 1'b1, 1'b0, 8'h03, 1'b1, 1'b0, 8'h01, 16'd2);

    // Failure code, then a pass write that must be ignored.
    do_reset();
    wr(16'h0200, 8'h9A);
    check_out("fail9a", 1'b1, 1'b0, 8'h9A, 1'b0, 1'b0, 8'h00, 16'd1);
    wr(16'h0200, 8'h00);
    idle(2);
    check_out("fail_hold", 1'b1, 1'b0, 8'h9A, 1'b0, 1'b0, 8'h00, 16'd1);

    // Other addresses and reads are ignored.
    do_reset();
    wr(16'h0201, 8'h00);
    wr(16'h0300, 8'h00);
    address  = 16'h0200;
    data_out = 8'h00;
    idle(1);
    check_out("other_addr", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 16'd3);
    wr(16'h0200, 8'h01);
    check_out("after_other", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h01, 16'd4);

    // Asynchronous reset mid-run, then monitoring resumes.
    do_reset();
    wr(16'h0200, 8'h01);
    wr(16'h0200, 8'h02);
    check_out("pre_rst", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h02, 16'd2);
    #2;
    reset = 1'b1;
    #1;
    check_out("async_rst", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 16'd0);
    @(negedge ph1);
    reset = 1'b0;
    wr(16'h0200, 8'h01);
    check_out("post_rst", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h01, 16'd1);

    // Full checkpoint range; after 8'h7F no checkpoint can be in order.
    do_reset();
    for (int i = 1; i <= 127; i++) begin
      wr(16'h0200, 8'(i));
    end
    check_out("ckpt7f", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h7F, 16'd127);
    wr(16'h0200, 8'h01);
    check_out("wrap_err", 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 8'h7F, 16'd128);

`ifdef TEST_MONITOR_WATCHDOG_EN
    // Watchdog expiry at RUN cycle 10.
    do_reset();
    idle(9);
    check_out("wd_pre", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 16'd9);
    idle(1);
    check_out("wd_expire", 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 16'd10);
    // Status write on the expiry edge wins.
    do_reset();
    idle(9);
    wr(16'h0200, 8'h00);
    check_out("wd_race", 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 16'd10);
`else
    // Without the watchdog the test never ends on its own.
    do_reset();
    idle(20);
    check_out("no_wd", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 16'd20);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
